key_filter_ctrl: RTL and testbench
==================================

Name: key_filter_ctrl

Overview:
Multi-key debounce and press-event generator. It sits directly upstream of the LED chaser and seven-segment/LCD control logic, and converts raw active-low push-button inputs into clean single-cycle events. Events: press, long-press, release, plus a debounced level. Each key is filtered independently by its own state machine and counter.

Parameters:
KEY_W, 4, number of key channels
DEB_CNT, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); simulation override 4
LONG_CNT, 50_000_000, hold time from debounced press to long-press event, in clk cycles (1 s at 50 MHz); simulation override 20
CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEB_CNT, LONG_CNT)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
key_in  input  KEY_W  raw buttons, active-low (0 = pressed), asynchronous to clk
key_press  output  KEY_W  one-cycle pulse per channel on a debounced press
key_long  output  KEY_W  one-cycle pulse when a press has been held LONG_CNT cycles
key_release  output  KEY_W  one-cycle pulse on a debounced release
key_level  output  KEY_W  debounced level, 1 = held

Behaviour:
- Reset (rst_n=0, asynchronous): synchronizer flops = 1 (released); all FSMs = IDLE; counters = 0; all outputs = 0. Reset mid-press drops any pending event, with no pulse on exit. A key still held after reset emits a press only after a full debounce.
- Per channel: a 2-flop synchronizer produces sync. The FSM acts only on sync.
- States: IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB. Per-channel long_flag records whether a long event has already fired.
- IDLE: if sync=0, go to PRESS_DB with cnt=0.
- PRESS_DB:
  - if sync=1, go to IDLE (bounce rejected, no event).
  - else if cnt=DEB_CNT-1, go to HELD, pulse key_press, cnt=0, long_flag=0.
  - else cnt+1.
- HELD:
  - if sync=1, go to RELEASE_DB with cnt=0.
  - else if cnt=LONG_CNT-1, go to LONG_HELD, pulse key_long, long_flag=1.
  - else cnt+1.
- LONG_HELD: if sync=1, go to RELEASE_DB with cnt=0. There is no auto-repeat and only one key_long per press.
- RELEASE_DB:
  - if sync=0, return to LONG_HELD when long_flag=1; otherwise return to HELD with cnt=0 (the long timer restarts).
  - else if cnt=DEB_CNT-1, go to IDLE and pulse key_release.
  - else cnt+1.
- key_level = 1 in HELD, LONG_HELD and RELEASE_DB; 0 otherwise. It is registered.
- All outputs are registered, and each pulse lasts exactly one clk cycle.
- Latency: key_press goes high in the cycle after rising edge E+2+DEB_CNT, where edge E is the first edge at which key_in is sampled low and held stable. Release timing is symmetric.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses in the same cycle.
- Counters never wrap: every comparison is equality against a parameter minus 1, and cnt always resets on state entry.

Decomposition:
- Shared package: the state encoding (3-bit localparams ST_IDLE..ST_RELEASE_DB) and the default DEB_CNT/LONG_CNT constants for 50 MHz, so the LED and segment blocks share the same timing base.
- One sub-module, key_filter_ch: a single-channel synchronizer, FSM and counter with 1-bit outputs.
- The top level instantiates KEY_W copies via generate and concatenates their outputs.

Test Plan:
All scenarios use DEB_CNT=4, LONG_CNT=20, KEY_W=4.
- Clean press: key_in[0] goes 1 to 0 and is held 10 cycles -> key_press[0] is a single pulse 7 cycles after the first low sample; key_level[0] goes to 1 in the same cycle; no other channel toggles.
- Bounce rejection: key_in[1] is low 3 cycles, high 1 cycle, low 2 cycles, then high -> no key_press[1] pulse, key_level[1] stays 0.
- Long press: key_in[2] is held low 40 cycles then released -> key_press[2] pulse, then exactly one key_long[2] pulse 20 cycles later, then a key_release[2] pulse 7 cycles after the release edge; no second key_long.
- Release bounce: during a hold of key_in[3], go high for 2 cycles, then low again for 30 cycles -> no key_release[3] pulse during the glitch; key_level[3] stays 1; key_long[3] fires 20 cycles after the glitch ends (timer restart).
- Simultaneous keys plus reset: key_in[0] and key_in[1] fall on the same edge -> key_press[0] and key_press[1] pulse in the same cycle. Then assert rst_n=0 for 2 cycles mid-hold -> all outputs are 0 immediately with no release pulse. With the keys still low after reset, new key_press pulses arrive 7 cycles after rst_n rises.

Source files
------------

// File: rtl/key_filter_ctrl_pkg.sv
// Shared definitions for the key filter and its neighbours (LED chaser,
// seven-segment/LCD control): per-channel state encoding and the default
// 50 MHz timing base.
package key_filter_ctrl_pkg;

    // Default timing at a 50 MHz clock.
    localparam int DEB_CNT_50M  = 1_000_000;   // 20 ms debounce window
    localparam int LONG_CNT_50M = 50_000_000;  // 1 s hold for a long press
    localparam int CNT_W_50M    = 26;          // 2^26 > LONG_CNT_50M

    // Per-channel debounce state machine encoding.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_LONG_HELD  = 3'd3,
        ST_RELEASE_DB = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_filter_ctrl_ch.sv
// Single key channel: 2-flop synchronizer, debounce FSM and shared counter.
// Produces registered one-cycle press/long/release pulses and a debounced level.
module key_filter_ctrl_ch
    import key_filter_ctrl_pkg::*;
#(
    parameter int DEB_CNT  = DEB_CNT_50M,
    parameter int LONG_CNT = LONG_CNT_50M,
    parameter int CNT_W    = CNT_W_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_press,
    output logic key_long,
    output logic key_release,
    output logic key_level
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    logic             sync1_reg, sync2_reg;
    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             long_flag_reg, long_flag_next;
    logic             press_reg, press_next;
    logic             long_reg, long_next;
    logic             release_reg, release_next;
    logic             level_reg, level_next;

    // Bring the raw asynchronous key into the clk domain; idles high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    // State, counter, long flag and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            long_flag_reg <= 1'b0;
            press_reg     <= 1'b0;
            long_reg      <= 1'b0;
            release_reg   <= 1'b0;
            level_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            long_flag_reg <= long_flag_next;
            press_reg     <= press_next;
            long_reg      <= long_next;
            release_reg   <= release_next;
            level_reg     <= level_next;
        end
    end

    // Next-state logic; the counter is cleared on every state entry so it never wraps.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        long_flag_next = long_flag_reg;
        press_next     = 1'b0;
        long_next      = 1'b0;
        release_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!sync2_reg) begin
                    state_next = ST_PRESS_DB;
                    cnt_next   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (sync2_reg) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next     = ST_HELD;
                    press_next     = 1'b1;
                    cnt_next       = '0;
                    long_flag_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (sync2_reg) begin
                    state_next = ST_RELEASE_DB;
                    cnt_next   = '0;
                end else if (cnt_reg == LONG_LAST) begin
                    state_next     = ST_LONG_HELD;
                    long_next      = 1'b1;
                    long_flag_next = 1'b1;
                    cnt_next       = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_LONG_HELD: begin
                // No auto-repeat: wait here until the key lets go.
                if (sync2_reg) begin
                    state_next = ST_RELEASE_DB;
                    cnt_next   = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (!sync2_reg) begin
                    // Release glitch: resume the hold; the long timer restarts
                    // unless the long event has already fired for this press.
                    state_next = long_flag_reg ? ST_LONG_HELD : ST_HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next   = ST_IDLE;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == ST_HELD) || (state_next == ST_LONG_HELD) ||
                     (state_next == ST_RELEASE_DB);
    end

    assign key_press   = press_reg;
    assign key_long    = long_reg;
    assign key_release = release_reg;
    assign key_level   = level_reg;

endmodule

// File: rtl/key_filter_ctrl.sv
// Multi-key debounce and event generator: KEY_W independent channels turning
// active-low raw buttons into press / long-press / release pulses and a level.
module key_filter_ctrl
    import key_filter_ctrl_pkg::*;
#(
    parameter int KEY_W    = 4,
    parameter int DEB_CNT  = DEB_CNT_50M,
    parameter int LONG_CNT = LONG_CNT_50M,
    parameter int CNT_W    = CNT_W_50M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_long,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_level
);

    // One fully independent filter per key.
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_ch
        key_filter_ctrl_ch #(
            .DEB_CNT  (DEB_CNT),
            .LONG_CNT (LONG_CNT),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_in      (key_in[gi]),
            .key_press   (key_press[gi]),
            .key_long    (key_long[gi]),
            .key_release (key_release[gi]),
            .key_level   (key_level[gi])
        );
    end

endmodule

// File: tb/tb_key_filter_ctrl.sv
// Directed bench for key_filter_ctrl with DEB_CNT=4, LONG_CNT=20, KEY_W=4.
// A negedge monitor records pulse counts and the edge index of each event;
// the stimulus block compares those against hand-computed edge numbers.
module tb_key_filter_ctrl;

    localparam int KEY_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_press, key_long, key_release, key_level;

    key_filter_ctrl #(
        .KEY_W    (KEY_W),
        .DEB_CNT  (4),
        .LONG_CNT (20),
        .CNT_W    (26)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_long    (key_long),
        .key_release (key_release),
        .key_level   (key_level)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int press_cnt[KEY_W]   = '{default: 0};
    int press_at[KEY_W]    = '{default: -1};
    int long_cnt[KEY_W]    = '{default: 0};
    int long_at[KEY_W]     = '{default: -1};
    int rel_cnt[KEY_W]     = '{default: 0};
    int rel_at[KEY_W]      = '{default: -1};
    int lvl_rise_cnt[KEY_W] = '{default: 0};
    int lvl_rise_at[KEY_W] = '{default: -1};
    int lvl_fall_at[KEY_W] = '{default: -1};
    logic [KEY_W-1:0] lvl_prev = '0;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < KEY_W; i++) begin
            if (key_press[i]) begin
                press_cnt[i] <= press_cnt[i] + 1;
                press_at[i]  <= edge_n;
            end
            if (key_long[i]) begin
                long_cnt[i] <= long_cnt[i] + 1;
                long_at[i]  <= edge_n;
            end
            if (key_release[i]) begin
                rel_cnt[i] <= rel_cnt[i] + 1;
                rel_at[i]  <= edge_n;
            end
            if (key_level[i] && !lvl_prev[i]) begin
                lvl_rise_cnt[i] <= lvl_rise_cnt[i] + 1;
                lvl_rise_at[i]  <= edge_n;
            end
            if (!key_level[i] && lvl_prev[i])
                lvl_fall_at[i] <= edge_n;
        end
        lvl_prev <= key_level;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int k;
    int r;

    initial begin
        key_in = '1;
        rst_n  = 1'b0;
        step(3);
        chk("rst_press",   int'(key_press),   0);
        chk("rst_long",    int'(key_long),    0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_level",   int'(key_level),   0);
        rst_n = 1'b1;
        step(3);

        // Clean press and release on key 0.
        k = edge_n;
        key_in[0] = 1'b0;
        step(10);
        key_in[0] = 1'b1;
        step(12);
        chk("t1_press_cnt",  press_cnt[0],   1);
        chk("t1_press_at",   press_at[0],    k + 7);
        chk("t1_level_at",   lvl_rise_at[0], k + 7);
        chk("t1_long_cnt",   long_cnt[0],    0);
        chk("t1_rel_cnt",    rel_cnt[0],     1);
        chk("t1_rel_at",     rel_at[0],      k + 17);
        chk("t1_others_lvl", lvl_rise_cnt[1] + lvl_rise_cnt[2] + lvl_rise_cnt[3], 0);

        // Bounce rejection on key 1.
        key_in[1] = 1'b0; step(3);
        key_in[1] = 1'b1; step(1);
        key_in[1] = 1'b0; step(2);
        key_in[1] = 1'b1; step(10);
        chk("t2_press_cnt", press_cnt[1],    0);
        chk("t2_level_cnt", lvl_rise_cnt[1], 0);
        chk("t2_rel_cnt",   rel_cnt[1],      0);

        // Long press on key 2.
        k = edge_n;
        key_in[2] = 1'b0;
        step(40);
        key_in[2] = 1'b1;
        step(12);
        chk("t3_press_at", press_at[2], k + 7);
        chk("t3_long_cnt", long_cnt[2], 1);
        chk("t3_long_at",  long_at[2],  k + 27);
        chk("t3_rel_cnt",  rel_cnt[2],  1);
        chk("t3_rel_at",   rel_at[2],   k + 47);

        // Release glitch on key 3 restarts the long timer.
        k = edge_n;
        key_in[3] = 1'b0; step(12);
        key_in[3] = 1'b1; step(2);
        key_in[3] = 1'b0; step(30);
        key_in[3] = 1'b1; step(12);
        chk("t4_press_at",  press_at[3],     k + 7);
        chk("t4_level_cnt", lvl_rise_cnt[3], 1);
        chk("t4_long_cnt",  long_cnt[3],     1);
        chk("t4_long_at",   long_at[3],      k + 37);
        chk("t4_rel_cnt",   rel_cnt[3],      1);
        chk("t4_rel_at",    rel_at[3],       k + 51);
        chk("t4_level_off", lvl_fall_at[3],  k + 51);

        // Simultaneous keys 0 and 1, then reset mid-hold.
        k = edge_n;
        key_in[1:0] = 2'b00;
        step(10);
        chk("t5_press_at0",  press_at[0],  k + 7);
        chk("t5_press_at1",  press_at[1],  k + 7);
        chk("t5_press_cnt0", press_cnt[0], 2);
        chk("t5_press_cnt1", press_cnt[1], 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_level", int'(key_level), 0);
        chk("t5_rst_press", int'(key_press), 0);
        step(2);
        chk("t5_rst_rel0", rel_cnt[0], 1);
        chk("t5_rst_rel1", rel_cnt[1], 0);
        r = edge_n;
        rst_n = 1'b1;
        step(10);
        chk("t5_repress_at0",  press_at[0],  r + 7);
        chk("t5_repress_at1",  press_at[1],  r + 7);
        chk("t5_repress_cnt0", press_cnt[0], 3);
        chk("t5_repress_cnt1", press_cnt[1], 2);
        chk("t5_no_rel0",      rel_cnt[0],   1);
        chk("t5_no_rel1",      rel_cnt[1],   0);
        chk("t5_level",        int'(key_level), 3);
        key_in[1:0] = 2'b11;
        step(12);
        chk("t5_rel_cnt0", rel_cnt[0], 2);
        chk("t5_rel_cnt1", rel_cnt[1], 1);
        chk("t5_level_end", int'(key_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
